// File: rtl/apb_efpga_pkg.sv
// Shared constants for the eFPGA HWCE APB requester: default parameter
// values and the FSM state encoding.
package apb_efpga_pkg;

    // Default width of the APB address and of the request address.
    localparam int DEF_APB_ADDR_WIDTH = 7;

    // Default abort limit in consecutive PREADY-low ACCESS cycles (0 = never abort).
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // FSM state encoding. Kept as plain constants so older tools read it too.
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_SETUP  = 2'd1;
    localparam logic [STATE_W-1:0] ST_ACCESS = 2'd2;
    localparam logic [STATE_W-1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_efpga_hwce_master.sv
// Single-outstanding APB requester. Takes one request at a time on a
// valid/ready port, runs the SETUP/ACCESS phases on APB, and returns the
// captured read data and error status on a valid/ready response port.
//
// Handshake rules for both ports: a transfer happens on the rising edge where
// valid and ready are both 1. The request port is ready only in IDLE; the
// response port holds valid and all response fields stable until rsp_ready_i
// is seen high, and valid never drops without that handshake (except reset).
//
// Wait-state watchdog: a counter clears when ACCESS is entered and counts the
// ACCESS cycles that see pready low. If the count reaches TIMEOUT_CYCLES the
// transfer is abandoned with err=1, timeout=1, rdata=0. pready=1 is checked
// first, so a completer answering on the limit cycle still completes normally.
module apb_efpga_hwce_master
    import apb_efpga_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = DEF_APB_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,

    output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
    output logic                      apb_psel_o,
    output logic                      apb_penable_o,
    output logic                      apb_pwrite_o,
    output logic [31:0]               apb_pwdata_o,
    input  logic [31:0]               apb_prdata_i,
    input  logic                      apb_pready_i,
    input  logic                      apb_pslverr_i,

    output logic [STATE_W-1:0]        dbg_state_o
);

    // Counter is wide enough to hold TIMEOUT_CYCLES itself.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    logic [STATE_W-1:0]        state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                      pwrite_q, pwrite_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic [CNT_W-1:0]          wait_q, wait_d;
    logic [31:0]               rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_timeout_q, rsp_timeout_d;

    logic [CNT_W-1:0]          wait_inc;

    // Saturating increment so a disabled timeout never wraps the counter.
    always_comb begin
        wait_inc = wait_q;
        if (wait_q != {CNT_W{1'b1}}) begin
            wait_inc = wait_q + 1'b1;
        end
    end

    // Next-state, request capture, wait counting and response capture.
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        wait_d        = wait_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    paddr_d  = req_addr_i;
                    pwrite_d = req_write_i;
                    pwdata_d = req_wdata_i;
                    state_d  = ST_SETUP;
                end
            end

            ST_SETUP: begin
                wait_d  = '0;
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (apb_pready_i) begin
                    rsp_rdata_d   = pwrite_q ? 32'h0 : apb_prdata_i;
                    rsp_err_d     = apb_pslverr_i;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    wait_d = wait_inc;
                    if (TIMEOUT_EN && (wait_inc == WAIT_LIMIT)) begin
                        rsp_rdata_d   = 32'h0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        state_d       = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= 32'h0;
            wait_q        <= '0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            wait_q        <= wait_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Outputs decoded from the state; penable is a subset of psel by construction.
    always_comb begin
        req_ready_o   = (state_q == ST_IDLE);
        apb_psel_o    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
        apb_penable_o = (state_q == ST_ACCESS);
        rsp_valid_o   = (state_q == ST_RESP);
        apb_paddr_o   = paddr_q;
        apb_pwrite_o  = pwrite_q;
        apb_pwdata_o  = pwdata_q;
        rsp_rdata_o   = rsp_rdata_q;
        rsp_err_o     = rsp_err_q;
        rsp_timeout_o = rsp_timeout_q;
        dbg_state_o   = state_q;
    end

endmodule

// File: tb/tb_apb_efpga_hwce_master.sv
// Bench for apb_efpga_hwce_master: a parameterisable APB completer model,
// a transaction driver, and one task per scenario with inline checks.
module tb_apb_efpga_hwce_master;
  import apb_efpga_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [6:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [1:0]  dbg_state;

  apb_efpga_hwce_master #(.APB_ADDR_WIDTH(7), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .apb_paddr_o(paddr), .apb_psel_o(psel), .apb_penable_o(penable),
    .apb_pwrite_o(pwrite), .apb_pwdata_o(pwdata), .apb_prdata_i(prdata),
    .apb_pready_i(pready), .apb_pslverr_i(pslverr),
    .dbg_state_o(dbg_state)
  );

  // ---------------- completer model ----------------
  int          slv_wait = 0;
  bit          slv_hang = 1'b0;
  bit          slv_err = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_cnt = 0;

  always @(posedge clk) begin
    if (rst || !(psel && penable) || pready) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
  end

  assign pready  = psel && penable && !slv_hang && (acc_cnt >= slv_wait);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err && pready;

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];   // {timeout, err, rdata}
  int n_checks = 0;
  int n_pass = 0;

  // observed values from the last run_txn
  int          o_lat, o_psel, o_pen;
  bit          o_hold, o_proto, o_acc, o_got;
  logic [31:0] o_rd;
  bit          o_err, o_tmo;

  // Drives one request from a negedge, follows it to the response, holds
  // rsp_ready low for bp cycles, then completes the handshake. Returns at the
  // negedge after the handshake edge.
  task automatic run_txn(input bit wr, input logic [6:0] addr, input logic [31:0] wd, input int bp);
    o_lat = 0; o_psel = 0; o_pen = 0; o_hold = 1; o_proto = 1; o_got = 0;
    o_rd = '0; o_err = 0; o_tmo = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    o_acc = req_ready;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (psel) begin
        o_psel++;
        if (paddr !== addr || pwdata !== wd || pwrite !== wr) o_hold = 0;
      end
      if (penable) o_pen++;
      if (penable && !psel) o_proto = 0;
      if (req_ready) o_proto = 0;
      if (rsp_valid) begin
        o_got = 1; o_lat = c;
        o_rd = rsp_rdata; o_err = rsp_err; o_tmo = rsp_timeout;
        break;
      end
    end
    if (o_got) begin
      for (int b = 0; b < bp; b++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_rdata !== o_rd || rsp_err !== o_err ||
            rsp_timeout !== o_tmo || req_ready !== 1'b0 || psel !== 1'b0) o_hold = 0;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%0b exp=1", req_ready); else n_pass++;
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0) $display("FAIL reset_psel got=%0b/%0b exp=0/0", psel, penable); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); else n_pass++;
    n_checks++; if (paddr !== 7'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) $display("FAIL reset_apb got=%h/%h/%0b exp=0", paddr, pwdata, pwrite); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) $display("FAIL reset_rsp got=%h/%0b/%0b exp=0", rsp_rdata, rsp_err, rsp_timeout); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); else n_pass++;
  endtask

  // Common checks on one completed transaction against the scoreboard.
  task automatic check_txn(input string nm, input int exp_lat, input int exp_psel, input int exp_pen);
    logic [33:0] e;
    n_checks++; if (!o_acc) $display("FAIL %s_accept req_ready=0 exp=1", nm); else n_pass++;
    n_checks++; if (!o_got) $display("FAIL %s_timeout_wait no response within bound", nm); else n_pass++;
    n_checks++; if (o_lat != exp_lat) $display("FAIL %s_latency got=%0d exp=%0d", nm, o_lat, exp_lat); else n_pass++;
    n_checks++; if (o_psel != exp_psel || o_pen != exp_pen) $display("FAIL %s_phases psel=%0d pen=%0d exp=%0d/%0d", nm, o_psel, o_pen, exp_psel, exp_pen); else n_pass++;
    n_checks++; if (!o_hold || !o_proto) $display("FAIL %s_protocol hold=%0b proto=%0b exp=1/1", nm, o_hold, o_proto); else n_pass++;
    e = exp_q.pop_front();
    n_checks++; if (o_rd !== e[31:0]) $display("FAIL %s_rdata got=%h exp=%h", nm, o_rd, e[31:0]); else n_pass++;
    n_checks++; if (o_err !== e[32] || o_tmo !== e[33]) $display("FAIL %s_status err=%0b tmo=%0b exp=%0b/%0b", nm, o_err, o_tmo, e[32], e[33]); else n_pass++;
  endtask

  task automatic test_read_zero_wait();
    slv_wait = 0; slv_err = 0; slv_hang = 0; slv_rdata = 32'h00DA41DE;
    exp_q.push_back({1'b0, 1'b0, 32'h00DA41DE});
    run_txn(1'b0, 7'h10, 32'h0, 0);
    check_txn("read0", 3, 2, 1);
  endtask

  task automatic test_write_wait();
    slv_wait = 3; slv_err = 0; slv_hang = 0; slv_rdata = 32'hFFFF_FFFF;
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    run_txn(1'b1, 7'h7F, 32'hCAFEF00D, 0);
    check_txn("write3", 6, 5, 4);
  endtask

  task automatic test_slave_error();
    slv_wait = 1; slv_err = 1; slv_hang = 0; slv_rdata = 32'h1234_5678;
    exp_q.push_back({1'b0, 1'b1, 32'h1234_5678});
    run_txn(1'b0, 7'h05, 32'h0, 0);
    check_txn("slverr", 4, 3, 2);
    slv_err = 0;
  endtask

  task automatic test_timeout();
    slv_wait = 0; slv_err = 0; slv_hang = 1; slv_rdata = 32'hDEAD_BEEF;
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    run_txn(1'b0, 7'h33, 32'h0, 0);
    check_txn("timeout", 18, 17, 16);
    slv_hang = 0;
  endtask

  task automatic test_timeout_boundary();
    // pready arrives on the 16th ACCESS cycle: must complete normally.
    slv_wait = 15; slv_err = 0; slv_hang = 0; slv_rdata = 32'hA5A5_0F0F;
    exp_q.push_back({1'b0, 1'b0, 32'hA5A5_0F0F});
    run_txn(1'b0, 7'h44, 32'h0, 0);
    check_txn("limit_win", 18, 17, 16);
  endtask

  task automatic test_backpressure_reset();
    slv_wait = 0; slv_err = 0; slv_hang = 0; slv_rdata = 32'h0BAD_F00D;
    exp_q.push_back({1'b0, 1'b0, 32'h0BAD_F00D});
    run_txn(1'b0, 7'h21, 32'h0, 5);
    check_txn("backpressure", 3, 2, 1);

    // Reset in the middle of an ACCESS phase.
    slv_hang = 1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h22; req_wdata = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (penable !== 1'b1) $display("FAIL rst_pre_access penable=%0b exp=1", penable); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    slv_hang = 0;
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0) $display("FAIL rst_mid_psel got=%0b/%0b exp=0/0", psel, penable); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_mid_ctrl rsp_valid=%0b req_ready=%0b exp=0/1", rsp_valid, req_ready); else n_pass++;
    n_checks++; if (paddr !== 7'h0 || pwdata !== 32'h0) $display("FAIL rst_mid_apb got=%h/%h exp=0/0", paddr, pwdata); else n_pass++;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_no_rsp rsp_valid=%0b exp=0", rsp_valid); else n_pass++;

    slv_rdata = 32'h600D_CAFE;
    exp_q.push_back({1'b0, 1'b0, 32'h600D_CAFE});
    run_txn(1'b0, 7'h23, 32'h0, 0);
    check_txn("after_rst", 3, 2, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      bit          wr;
      logic [6:0]  a;
      logic [31:0] d;
      wr = 1'($urandom_range(0, 1));
      a  = 7'($urandom_range(0, 127));
      d  = $urandom;
      slv_wait  = $urandom_range(0, 4);
      slv_err   = 1'($urandom_range(0, 1));
      slv_rdata = $urandom;
      slv_hang  = 0;
      n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_idle_%0d req_ready=%0b exp=1", i, req_ready); else n_pass++;
      exp_q.push_back({1'b0, slv_err, wr ? 32'h0 : slv_rdata});
      run_txn(wr, a, d, $urandom_range(0, 2));
      check_txn($sformatf("b2b%0d", i), 3 + slv_wait, 2 + slv_wait, 1 + slv_wait);
    end
    slv_err = 0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_slave_error();
    test_timeout();
    test_timeout_boundary();
    test_backpressure_reset();
    test_back_to_back();
    n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global safety bound on simulated time.
  initial begin
    #200000;
    $display("FAIL sim_time_bound exceeded");
    $fatal(1);
  end

endmodule
